mem_stage: RTL and testbench

- MEM stage of the 5-stage 16-bit pipeline; sits directly downstream of the EX/MEM pipeline register and consumes its ex_mem_* outputs.
- Drives a variable-latency data-memory interface (level request, done strobe) and stalls the upstream pipeline while an access is outstanding.
- Checks address alignment, enforces a watchdog timeout, and owns the MEM/WB pipeline register (mem_wb_* outputs).

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_if.sv | 22 ++
 rtl/mem_wb_reg.sv | 22 ++
 rtl/mem_stage.sv | 170 +++++++++++++++++
 tb/tb_mem_stage.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM stage: FSM states, MemToReg encodings
// and the MEM/WB payload.
package mem_pkg;

    localparam int unsigned XLEN            = 16;
    localparam int unsigned REGW            = 3;
    localparam int unsigned DEFAULT_TIMEOUT = 64;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC  = 2'b10;

    // One MEM/WB pipeline entry; an all-zero value is a bubble.
    typedef struct packed {
        logic [XLEN-1:0] read_data;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] pc_updated;
        logic [1:0]      mem_to_reg;
        logic [REGW-1:0] write_register;
        logic            reg_write;
        logic            halt;
        logic            err;
    } mem_wb_t;

endpackage

// File: rtl/mem_if.sv
// Data-memory bus: level request from the stage, done strobe plus read data from memory.
interface mem_if;
    import mem_pkg::*;

    logic            mem_req;
    logic            mem_wr;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_done;

    modport master (
        output mem_req, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_done
    );

    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_done
    );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble loads an all-zero entry.
module mem_wb_reg
    import mem_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    bubble,
    input  mem_wb_t d,
    output mem_wb_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: drives the variable-latency data memory, stalls upstream, aborts on watchdog
// timeout and owns MEM/WB. Optional counters under `define MEM_STAGE_PERF_EN.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_mem_memRead,
    input  logic            ex_mem_memWrite,
    input  logic [XLEN-1:0] ex_mem_aluResult,
    input  logic [XLEN-1:0] ex_mem_writeData,
    input  logic [XLEN-1:0] ex_mem_PC_Updated,
    input  logic [1:0]      ex_mem_MemToReg,
    input  logic [REGW-1:0] ex_mem_Write_Register,
    input  logic            ex_mem_RegWrite,
    input  logic            ex_mem_halt,
    mem_if.master           mem_bus,
    output logic            mem_stall,
    output logic [XLEN-1:0] mem_wb_readData,
    output logic [XLEN-1:0] mem_wb_aluResult,
    output logic [XLEN-1:0] mem_wb_PC_Updated,
    output logic [1:0]      mem_wb_MemToReg,
    output logic [REGW-1:0] mem_wb_Write_Register,
    output logic            mem_wb_RegWrite,
    output logic            mem_wb_halt,
    output logic            mem_wb_err,
    output logic            err_sticky
`ifdef MEM_STAGE_PERF_EN
    ,
    output logic [15:0]     perf_access,
    output logic [15:0]     perf_stall
`endif
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            op, mis;
    logic            req_c, stall_c, bubble_c, err_c, take_rdata_c;
    mem_wb_t         wb_d, wb_q;

    assign op  = ex_mem_memRead | ex_mem_memWrite;
    assign mis = op & ex_mem_aluResult[0];

    // A simultaneous read+write request is a write.
    assign mem_bus.mem_addr  = ex_mem_aluResult;
    assign mem_bus.mem_wdata = ex_mem_writeData;
    assign mem_bus.mem_wr    = ex_mem_memWrite;

    // Gated by rst_n so request and stall drop the moment reset asserts.
    assign mem_bus.mem_req = req_c & rst_n;
    assign mem_stall       = stall_c & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        req_c        = 1'b0;
        stall_c      = 1'b0;
        bubble_c     = 1'b0;
        err_c        = 1'b0;
        take_rdata_c = 1'b0;
        unique case (state)
            IDLE: begin
                if (mis) begin
                    err_c = 1'b1;
                end else if (op) begin
                    req_c = 1'b1;
                    if (mem_bus.mem_done) begin
                        take_rdata_c = 1'b1;
                    end else begin
                        stall_c   = 1'b1;
                        bubble_c  = 1'b1;
                        state_nxt = WAIT;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            WAIT: begin
                req_c = 1'b1;
                if (mem_bus.mem_done) begin
                    take_rdata_c = 1'b1;
                    state_nxt    = IDLE;
                    cnt_nxt      = '0;
                end else if (cnt == CW'(TIMEOUT)) begin
                    // Watchdog abort: retire the instruction with an error, no writeback.
                    req_c     = 1'b0;
                    err_c     = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    cnt_nxt  = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wb_d                = '0;
        wb_d.read_data      = take_rdata_c ? mem_bus.mem_rdata : '0;
        wb_d.alu_result     = ex_mem_aluResult;
        wb_d.pc_updated     = ex_mem_PC_Updated;
        wb_d.mem_to_reg     = ex_mem_MemToReg;
        wb_d.write_register = ex_mem_Write_Register;
        wb_d.reg_write      = ex_mem_RegWrite & ~err_c;
        wb_d.halt           = ex_mem_halt;
        wb_d.err            = err_c;
    end

    mem_wb_reg u_mem_wb_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .bubble (bubble_c),
        .d      (wb_d),
        .q      (wb_q)
    );

    assign mem_wb_readData       = wb_q.read_data;
    assign mem_wb_aluResult      = wb_q.alu_result;
    assign mem_wb_PC_Updated     = wb_q.pc_updated;
    assign mem_wb_MemToReg       = wb_q.mem_to_reg;
    assign mem_wb_Write_Register = wb_q.write_register;
    assign mem_wb_RegWrite       = wb_q.reg_write;
    assign mem_wb_halt           = wb_q.halt;
    assign mem_wb_err            = wb_q.err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (err_c) begin
            err_sticky <= 1'b1;
        end
    end

`ifdef MEM_STAGE_PERF_EN
    logic issue_c;
    assign issue_c = (state == IDLE) & op & ~mis;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_access <= '0;
            perf_stall  <= '0;
        end else begin
            if (issue_c && perf_access != 16'hFFFF) begin
                perf_access <= perf_access + 16'd1;
            end
            if (stall_c && perf_stall != 16'hFFFF) begin
                perf_stall <= perf_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand sequences for reset/halt,
// and randomized instructions checked against a transaction-level model.
module tb_mem_stage;
    import mem_pkg::*;

    localparam int unsigned TO = 4;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] pc;
        logic [1:0]  mtr;
        logic [2:0]  wreg;
        bit          rw;
        bit          halt;
        int          lat;
        logic [15:0] rdata;
        int          exp_stalls;
        bit          exp_err;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        ex_mem_memRead, ex_mem_memWrite, ex_mem_RegWrite, ex_mem_halt;
    logic [15:0] ex_mem_aluResult, ex_mem_writeData, ex_mem_PC_Updated;
    logic [1:0]  ex_mem_MemToReg;
    logic [2:0]  ex_mem_Write_Register;
    logic        mem_stall;
    logic [15:0] mem_wb_readData, mem_wb_aluResult, mem_wb_PC_Updated;
    logic [1:0]  mem_wb_MemToReg;
    logic [2:0]  mem_wb_Write_Register;
    logic        mem_wb_RegWrite, mem_wb_halt, mem_wb_err, err_sticky;

    int n_cmp = 0;
    int n_bad = 0;
    int halt_seen = 0;
    bit sticky_m = 0;

    mem_if bus ();

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .ex_mem_memRead        (ex_mem_memRead),
        .ex_mem_memWrite       (ex_mem_memWrite),
        .ex_mem_aluResult      (ex_mem_aluResult),
        .ex_mem_writeData      (ex_mem_writeData),
        .ex_mem_PC_Updated     (ex_mem_PC_Updated),
        .ex_mem_MemToReg       (ex_mem_MemToReg),
        .ex_mem_Write_Register (ex_mem_Write_Register),
        .ex_mem_RegWrite       (ex_mem_RegWrite),
        .ex_mem_halt           (ex_mem_halt),
        .mem_bus               (bus),
        .mem_stall             (mem_stall),
        .mem_wb_readData       (mem_wb_readData),
        .mem_wb_aluResult      (mem_wb_aluResult),
        .mem_wb_PC_Updated     (mem_wb_PC_Updated),
        .mem_wb_MemToReg       (mem_wb_MemToReg),
        .mem_wb_Write_Register (mem_wb_Write_Register),
        .mem_wb_RegWrite       (mem_wb_RegWrite),
        .mem_wb_halt           (mem_wb_halt),
        .mem_wb_err            (mem_wb_err),
        .err_sticky            (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (mem_wb_halt) halt_seen++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mem_wb_t wb_now();
        return {mem_wb_readData, mem_wb_aluResult, mem_wb_PC_Updated, mem_wb_MemToReg,
                mem_wb_Write_Register, mem_wb_RegWrite, mem_wb_halt, mem_wb_err};
    endfunction

    task automatic drive_idle();
        ex_mem_memRead = 0; ex_mem_memWrite = 0; ex_mem_RegWrite = 0; ex_mem_halt = 0;
        ex_mem_aluResult = '0; ex_mem_writeData = '0; ex_mem_PC_Updated = '0;
        ex_mem_MemToReg = '0; ex_mem_Write_Register = '0;
        bus.mem_done = 0; bus.mem_rdata = '0;
    endtask

    // Outcome of one instruction from the stage's rules: how many stalled cycles and whether it errs.
    function automatic vec_t ref_outcome(input vec_t v);
        vec_t r = v;
        bit   is_mem = v.rd || v.wr;
        bit   odd = (v.addr % 2) == 1;
        bit   issued = is_mem && !odd;
        r.exp_stalls = !issued ? 0 : ((v.lat < int'(TO)) ? v.lat : int'(TO));
        r.exp_err    = (is_mem && odd) || (issued && v.lat > int'(TO));
        return r;
    endfunction

    // Applies one instruction (called just after a rising edge) and checks every cycle it occupies.
    task automatic run_instr(input vec_t v);
        bit      issued = (v.rd || v.wr) && !v.addr[0];
        int      n = v.exp_stalls;
        mem_wb_t fin, exp_wb;
        fin = '0;
        fin.read_data      = (issued && !v.exp_err) ? v.rdata : 16'h0;
        fin.alu_result     = v.addr;
        fin.pc_updated     = v.pc;
        fin.mem_to_reg     = v.mtr;
        fin.write_register = v.wreg;
        fin.reg_write      = v.rw && !v.exp_err;
        fin.halt           = v.halt;
        fin.err            = v.exp_err;
        ex_mem_memRead = v.rd; ex_mem_memWrite = v.wr; ex_mem_aluResult = v.addr;
        ex_mem_writeData = v.wdata; ex_mem_PC_Updated = v.pc; ex_mem_MemToReg = v.mtr;
        ex_mem_Write_Register = v.wreg; ex_mem_RegWrite = v.rw; ex_mem_halt = v.halt;
        bus.mem_rdata = v.rdata;
        for (int c = 0; c <= n; c++) begin
            bus.mem_done = issued ? (c == v.lat) : 1'($urandom % 2);
            @(negedge clk);
            chk("bus_comb", {bus.mem_req, mem_stall, bus.mem_wr, bus.mem_addr, bus.mem_wdata},
                {issued && !(c == n && v.exp_err), c < n, v.wr, v.addr, v.wdata});
            @(posedge clk); #1;
            exp_wb = (c < n) ? mem_wb_t'('0) : fin;
            chk("mem_wb", 64'(wb_now()), 64'(exp_wb));
            if (c == n && v.exp_err) sticky_m = 1;
            chk("err_sticky", 64'(err_sticky), 64'(sticky_m));
        end
    endtask

    vec_t tbl[$];
    vec_t v;

    function automatic vec_t mk(bit rd, bit wr, logic [15:0] addr, logic [15:0] wdata, bit rw,
                                bit halt, int lat, logic [15:0] rdata, int stalls, bit err);
        vec_t r;
        r.rd = rd; r.wr = wr; r.addr = addr; r.wdata = wdata; r.pc = addr + 16'h0102;
        r.mtr = rd ? MTR_MEM : MTR_ALU; r.wreg = 3'(addr[4:2] + 3'd1); r.rw = rw; r.halt = halt;
        r.lat = lat; r.rdata = rdata; r.exp_stalls = stalls; r.exp_err = err;
        return r;
    endfunction

    initial begin
        // rd wr addr wdata rw halt lat rdata | stalls err
        tbl.push_back(mk(1, 0, 16'h0010, 16'h0000, 1, 0,  0, 16'hBEEF, 0, 0)); // load hit
        tbl.push_back(mk(0, 1, 16'h0020, 16'h1234, 0, 0,  2, 16'h5A5A, 2, 0)); // store, done on 3rd cycle
        tbl.push_back(mk(1, 0, 16'h0011, 16'h0000, 1, 0,  0, 16'h7777, 0, 1)); // misaligned load
        tbl.push_back(mk(0, 0, 16'h0123, 16'h4444, 1, 0,  0, 16'h9999, 0, 0)); // ALU op
        tbl.push_back(mk(1, 0, 16'h0040, 16'h0000, 1, 0, 99, 16'h1111, 4, 1)); // timeout
        tbl.push_back(mk(1, 1, 16'h0030, 16'hCAFE, 1, 0,  1, 16'h2222, 1, 0)); // rd+wr acts as write
        tbl.push_back(mk(1, 0, 16'h0062, 16'h0000, 1, 0,  4, 16'h3333, 4, 0)); // done on the last legal cycle
        tbl.push_back(mk(1, 0, 16'h0070, 16'h0000, 1, 1,  2, 16'h4444, 2, 0)); // halt rides a slow load
        tbl.push_back(mk(0, 1, 16'h0005, 16'h6666, 0, 0,  0, 16'h0000, 0, 1)); // misaligned store
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 1, 0,  0, 16'h0000, 0, 0)); // nop

        drive_idle();
        rst_n = 0;
        ex_mem_memRead = 1; ex_mem_aluResult = 16'h0010;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_stall", {bus.mem_req, mem_stall}, 2'b00);
        chk("reset_mem_wb", 64'(wb_now()), 64'(0));
        chk("reset_sticky", 64'(err_sticky), 64'(0));
        drive_idle();
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        foreach (tbl[i]) run_instr(tbl[i]);

        // Halt marker lands exactly once, after the preceding load.
        halt_seen = 0;
        run_instr(mk(1, 0, 16'h0080, 16'h0000, 1, 0, 1, 16'hABCD, 1, 0));
        run_instr(mk(0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000, 0, 0));
        run_instr(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
        chk("halt_once", 64'(halt_seen), 64'(1));

        // Reset in the middle of a pending load.
        chk("sticky_before_reset", 64'(err_sticky), 64'(1));
        drive_idle();
        ex_mem_memRead = 1; ex_mem_RegWrite = 1; ex_mem_aluResult = 16'h0050;
        @(negedge clk);
        chk("pend_req_stall", {bus.mem_req, mem_stall}, 2'b11);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        chk("midwait_req_stall", {bus.mem_req, mem_stall}, 2'b00);
        chk("midwait_mem_wb", 64'(wb_now()), 64'(0));
        chk("midwait_sticky", 64'(err_sticky), 64'(0));
        sticky_m = 0;
        drive_idle();
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        run_instr(mk(1, 0, 16'h0090, 16'h0000, 1, 0, 0, 16'h0F0F, 0, 0));

        for (int k = 0; k < 300; k++) begin
            v.rd    = ($urandom % 3) == 0;
            v.wr    = ($urandom % 4) == 0;
            v.addr  = 16'($urandom);
            if (($urandom % 8) != 0) v.addr[0] = 1'b0;
            v.wdata = 16'($urandom);
            v.pc    = 16'($urandom);
            v.mtr   = 2'($urandom % 3);
            v.wreg  = 3'($urandom);
            v.rw    = 1'($urandom);
            v.halt  = ($urandom % 16) == 0;
            v.lat   = int'($urandom_range(0, 6));
            v.rdata = 16'($urandom);
            run_instr(ref_outcome(v));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
